ingress_voq_port: RTL and testbench

Parametrised ingress port for the daFPGASwitch datapath. It accepts 32-bit packet words from the packet generator and stores each packet in a fixed-size slot of an internal dual-port data memory. It queues a descriptor in one of `PORTS` virtual output queues (VOQs) and, on a scheduler grant, streams the granted packet to the crossbar. It replaces hard-wired 4-port ingress logic with configurable port count, slot count and slot size, adds a drop policy, and provides sized, cycle-exact dequeue.

---
 rtl/ingress_voq_port.sv | 218 +++++++++++++++++++++
 tb/tb_ingress_voq_port.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ingress_voq_port.sv
// rtl/ingress_voq_port.sv - ingress port: slot-based packet store, per-egress VOQs, sized dequeue
//
// Optional feature macro: INGRESS_TIMESTAMP_EN (word 1 of stored packets replaced by a cycle stamp)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_data/valid/sop   packet words from the generator, no backpressure
//   voq_nonempty        per-VOQ "holds a descriptor" flags
//   sched_grant/sel     scheduler dequeue request and VOQ select
//   out_busy            dequeue in progress, grants ignored
//   out_data/valid/sop/eop  packet words to the crossbar
//   drop_count          saturating count of dropped packets
module ingress_voq_port #(
  parameter int PORTS      = 4,
  parameter int SLOTS      = 16,
  parameter int SLOT_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              in_data,
  input  logic                     in_valid,
  input  logic                     in_sop,
  output logic [PORTS-1:0]         voq_nonempty,
  input  logic                     sched_grant,
  input  logic [$clog2(PORTS)-1:0] sched_sel,
  output logic                     out_busy,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [15:0]              drop_count
);
  localparam int PW = $clog2(PORTS);
  localparam int SW = $clog2(SLOTS);
  localparam int WW = $clog2(SLOT_WORDS);
  localparam int LW = WW + 1;          // holds len up to SLOT_WORDS
  localparam int CW = SW + 1;          // holds counts up to SLOTS
  localparam int AW = SW + WW;
  localparam int DW = SW + LW;         // descriptor {slot, len}

  typedef enum logic [1:0] {IN_IDLE, IN_BODY, IN_DROP} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_READ} out_state_t;

  in_state_t  in_state;
  out_state_t out_state;

  logic [31:0]   data_mem [SLOTS*SLOT_WORDS];
  logic [31:0]   rd_q;
  logic [SW-1:0] fl_mem [SLOTS];
  logic [SW-1:0] fl_wr, fl_rd, fl_head;
  logic [CW-1:0] fl_cnt;
  logic [DW-1:0] voq_mem [PORTS*SLOTS];
  logic [SW-1:0] voq_wr [PORTS];
  logic [SW-1:0] voq_rd [PORTS];
  logic [CW-1:0] voq_cnt [PORTS];

  logic [SW-1:0] in_slot, rd_slot;
  logic [LW-1:0] in_len, in_idx, rd_len, rd_idx;
  logic [PW-1:0] in_dst, enq_dst;
  logic [11:0]   hdr_len;
  logic          sop_v, hdr_bad, hdr_ok, hdr_drop, trunc, body_wr, body_last;
  logic          enq, deq, rel, wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0]   wr_data;
  logic [DW-1:0] enq_desc, deq_desc;
  logic [16:0]   drop_sum;

  always_comb begin
    fl_head   = fl_mem[fl_rd];
    hdr_len   = in_data[11:0];
    sop_v     = in_valid && in_sop;
    hdr_bad   = (hdr_len == 12'd0) || (hdr_len > 12'(SLOT_WORDS)) || (fl_cnt == '0);
    hdr_ok    = sop_v && !hdr_bad;
    hdr_drop  = sop_v && hdr_bad;
    // A sop inside a packet abandons it; its slot goes back to the free list.
    trunc     = sop_v && (in_state == IN_BODY);
    body_wr   = in_valid && !in_sop && (in_state == IN_BODY);
    body_last = body_wr && (in_idx == in_len - LW'(1));
    enq       = (hdr_ok && hdr_len == 12'd1) || body_last;
    enq_dst   = body_last ? in_dst : in_data[16 +: PW];
    enq_desc  = body_last ? {in_slot, in_len} : {fl_head, LW'(1)};
    wr_en     = hdr_ok || body_wr;
    wr_addr   = hdr_ok ? {fl_head, WW'(0)} : {in_slot, in_idx[WW-1:0]};
    deq       = (out_state == OUT_IDLE) && sched_grant && voq_nonempty[sched_sel];
    deq_desc  = voq_mem[{sched_sel, voq_rd[sched_sel]}];
    rel       = (out_state == OUT_READ) && (rd_idx == rd_len - LW'(1));
    rd_addr   = {rd_slot, rd_idx[WW-1:0]};
    drop_sum  = {1'b0, drop_count} + 17'(hdr_drop) + 17'(trunc);
    for (int p = 0; p < PORTS; p++) voq_nonempty[p] = (voq_cnt[p] != '0);
  end

`ifdef INGRESS_TIMESTAMP_EN
  logic [31:0] ts_cnt, hdr_ts;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= '0;
      hdr_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (hdr_ok) hdr_ts <= ts_cnt;
    end
  end

  assign wr_data = (body_wr && in_idx == LW'(1)) ? hdr_ts : in_data;
`else
  assign wr_data = in_data;
`endif

  // Input FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state <= IN_IDLE;
      in_slot  <= '0;
      in_len   <= '0;
      in_idx   <= '0;
      in_dst   <= '0;
    end else if (sop_v) begin
      if (hdr_ok && hdr_len != 12'd1) begin
        in_state <= IN_BODY;
        in_slot  <= fl_head;
        in_len   <= hdr_len[LW-1:0];
        in_idx   <= LW'(1);
        in_dst   <= in_data[16 +: PW];
      end else if (hdr_ok) begin
        in_state <= IN_IDLE;
      end else begin
        in_state <= IN_DROP;
      end
    end else if (body_last) begin
      in_state <= IN_IDLE;
    end else if (body_wr) begin
      in_idx <= in_idx + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else       drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Free list: up to two returns (truncation, dequeue release) and one pop per cycle.
  // The pop reads an entry already present, so a slot returned this cycle is never reissued.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) fl_mem[i] <= SW'(i);
      fl_wr  <= '0;
      fl_rd  <= '0;
      fl_cnt <= CW'(SLOTS);
    end else begin
      if (trunc) fl_mem[fl_wr] <= in_slot;
      if (rel)   fl_mem[fl_wr + SW'(trunc)] <= rd_slot;
      if (hdr_ok) fl_rd <= fl_rd + SW'(1);
      fl_wr  <= fl_wr + SW'(trunc) + SW'(rel);
      fl_cnt <= fl_cnt + CW'(trunc) + CW'(rel) - CW'(hdr_ok);
    end
  end

  // VOQ descriptor storage and pointers
  always_ff @(posedge clk) begin
    if (enq) voq_mem[{enq_dst, voq_wr[enq_dst]}] <= enq_desc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PORTS; p++) begin
        voq_wr[p]  <= '0;
        voq_rd[p]  <= '0;
        voq_cnt[p] <= '0;
      end
    end else begin
      if (enq) voq_wr[enq_dst] <= voq_wr[enq_dst] + SW'(1);
      if (deq) voq_rd[sched_sel] <= voq_rd[sched_sel] + SW'(1);
      for (int p = 0; p < PORTS; p++)
        voq_cnt[p] <= voq_cnt[p] + CW'(enq && enq_dst == PW'(p))
                                 - CW'(deq && sched_sel == PW'(p));
    end
  end

  // Output FSM; flags are registered alongside the 1-cycle memory read.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state <= OUT_IDLE;
      rd_slot   <= '0;
      rd_len    <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      out_valid <= (out_state == OUT_READ);
      out_sop   <= (out_state == OUT_READ) && (rd_idx == '0);
      out_eop   <= rel;
      case (out_state)
        OUT_IDLE: if (deq) begin
          rd_slot   <= deq_desc[DW-1:LW];
          rd_len    <= deq_desc[LW-1:0];
          rd_idx    <= '0;
          out_state <= OUT_READ;
        end
        OUT_READ: begin
          if (rel) out_state <= OUT_IDLE;
          else     rd_idx <= rd_idx + LW'(1);
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_mem[wr_addr] <= wr_data;
    rd_q <= data_mem[rd_addr];
  end

  assign out_busy = (out_state == OUT_READ);
  assign out_data = out_valid ? rd_q : 32'd0;

endmodule

// File: tb/tb_ingress_voq_port.sv
// tb/tb_ingress_voq_port.sv - directed self-checking bench for ingress_voq_port
module tb_ingress_voq_port;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid, in_sop;
  logic [3:0]  voq_nonempty;
  logic        sched_grant;
  logic [1:0]  sched_sel;
  logic        out_busy;
  logic [31:0] out_data;
  logic        out_valid, out_sop, out_eop;
  logic [15:0] drop_count;

  int n_vec  = 0;
  int n_miss = 0;

  ingress_voq_port #(.PORTS(4), .SLOTS(16), .SLOT_WORDS(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .voq_nonempty(voq_nonempty),
    .sched_grant(sched_grant), .sched_sel(sched_sel),
    .out_busy(out_busy), .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Header carries 0xA5 in the ignored top byte; body word i is base+i.
  function automatic logic [31:0] pword(input int dstf, input int len, input int base, input int i);
    if (i == 0) return {8'hA5, 8'(dstf), 4'h0, 12'(len)};
    return 32'(base + i);
  endfunction

  // Drive the first nwords words of a packet, one per cycle, then idle.
  task automatic send_pkt(input int dstf, input int len, input int base, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_data  = pword(dstf, len, base, i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 32'd0;
  endtask

  // Grant VOQ sel in cycle T; optionally hold the grant into T+1 (busy) on busy_sel.
  // Checks word i in T+2+i with flags {valid, sop, eop, busy}.
  task automatic grant_check(input int sel, input int dstf, input int len, input int base,
                             input int busy_sel, input string tag);
    @(negedge clk);
    sched_grant = 1'b1;
    sched_sel   = 2'(sel);
    @(negedge clk);
    if (busy_sel >= 0) sched_sel = 2'(busy_sel);
    else sched_grant = 1'b0;
    expect_eq({tag, ".t1"}, 32'({out_busy, out_valid}), 32'b10);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      sched_grant = 1'b0;
      expect_eq($sformatf("%s.flags%0d", tag, i), 32'({out_valid, out_sop, out_eop, out_busy}),
                32'({1'b1, i == 0, i == len - 1, (i + 2) <= len}));
      expect_eq($sformatf("%s.data%0d", tag, i), out_data, pword(dstf, len, base, i));
    end
    @(negedge clk);
    expect_eq({tag, ".tail"}, 32'({out_busy, out_valid}), 32'b00);
  endtask

  initial begin
    reset = 1'b1; in_data = 32'd0; in_valid = 1'b0; in_sop = 1'b0;
    sched_grant = 1'b0; sched_sel = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_eq("rst.voq",   32'(voq_nonempty), 32'd0);
    expect_eq("rst.flags", 32'({out_busy, out_valid, out_sop, out_eop}), 32'd0);
    expect_eq("rst.data",  out_data, 32'd0);
    expect_eq("rst.drop",  32'(drop_count), 32'd0);

    // Single packet; dst field 0x06 decodes to port 2.
    send_pkt(6, 4, 32'h1000, 4);
    expect_eq("single.voq", 32'(voq_nonempty), 32'b0100);
    grant_check(2, 6, 4, 32'h1000, -1, "single");
    expect_eq("single.voq_after", 32'(voq_nonempty), 32'd0);

    // Bad lengths
    send_pkt(1, 0, 0, 1);
    send_pkt(1, 9, 0, 1);
    expect_eq("badlen.drop", 32'(drop_count), 32'd2);
    expect_eq("badlen.voq",  32'(voq_nonempty), 32'd0);

    // Truncation: sop arrives as the 3rd word of a 6-word packet
    send_pkt(0, 6, 32'h2000, 2);
    send_pkt(1, 3, 32'h3000, 3);
    expect_eq("trunc.drop",   32'(drop_count), 32'd3);
    expect_eq("trunc.voq",    32'(voq_nonempty), 32'b0010);
    expect_eq("trunc.fl_mid", 32'(dut.fl_cnt), 32'd15);
    grant_check(1, 1, 3, 32'h3000, -1, "trunc");
    expect_eq("trunc.fl_end", 32'(dut.fl_cnt), 32'd16);

    // Scheduler edges
    send_pkt(0, 4, 32'h4000, 4);
    send_pkt(3, 1, 0, 1);
    send_pkt(1, 1, 0, 1);
    expect_eq("sched.voq", 32'(voq_nonempty), 32'b1011);
    @(negedge clk); sched_grant = 1'b1; sched_sel = 2'd2;
    @(negedge clk); sched_grant = 1'b0;
    expect_eq("empty.busy", 32'(out_busy), 32'd0);
    @(negedge clk);
    expect_eq("empty.valid", 32'(out_valid), 32'd0);
    expect_eq("empty.voq", 32'(voq_nonempty), 32'b1011);
    grant_check(0, 0, 4, 32'h4000, 3, "busygnt");
    expect_eq("busygnt.voq", 32'(voq_nonempty), 32'b1010);

    // Grant VOQ3 in T; grant held on VOQ1 is ignored in T+1 (busy), accepted in T+2.
    @(negedge clk); sched_grant = 1'b1; sched_sel = 2'd3;
    @(negedge clk); sched_sel = 2'd1;
    expect_eq("b2b.t1", 32'({out_busy, out_valid}), 32'b10);
    @(negedge clk);
    expect_eq("b2b.a_flags", 32'({out_valid, out_sop, out_eop, out_busy}), 32'b1110);
    expect_eq("b2b.a_data",  out_data, pword(3, 1, 0, 0));
    @(negedge clk); sched_grant = 1'b0;
    expect_eq("b2b.t3", 32'({out_busy, out_valid}), 32'b10);
    @(negedge clk);
    expect_eq("b2b.b_flags", 32'({out_valid, out_sop, out_eop, out_busy}), 32'b1110);
    expect_eq("b2b.b_data",  out_data, pword(1, 1, 0, 0));
    @(negedge clk);
    expect_eq("b2b.tail", 32'({out_valid, voq_nonempty}), 32'd0);

    // Exhaustion: 17 full-size packets into 16 slots
    for (int p = 0; p < 17; p++) send_pkt(p % 4, 8, 32'h5000 + p * 16, 8);
    expect_eq("exh.drop", 32'(drop_count), 32'd4);
    expect_eq("exh.voq",  32'(voq_nonempty), 32'b1111);
    expect_eq("exh.fl",   32'(dut.fl_cnt), 32'd0);
    grant_check(0, 0, 8, 32'h5000, -1, "exh.p0");
    send_pkt(0, 8, 32'h6000, 8);
    expect_eq("refill.drop", 32'(drop_count), 32'd4);
    expect_eq("refill.fl",   32'(dut.fl_cnt), 32'd0);
    for (int p = 4; p < 16; p += 4)
      grant_check(0, 0, 8, 32'h5000 + p * 16, -1, $sformatf("exh.p%0d", p));
    grant_check(0, 0, 8, 32'h6000, -1, "refill");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
